// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode definitions for the registered ALU.
//   OP_* : 3-bit function select codes used by alu_core and alu.
package alu_pkg;
   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_MOD  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_SHR  = 3'b110;
   localparam logic [2:0] OP_GT   = 3'b111;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 8-function compute stage.
//   a, b   : W-bit unsigned operands
//   sel    : 3-bit function select
//   result : W+1-bit result (operands zero-extended before operating)
//   dz     : divide/modulo by zero flag
module alu_core
   import alu_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   sel,
   output logic [W:0]   result,
   output logic         dz
);
   logic [W:0] ae, be;
   logic       bz;
   assign ae = {1'b0, a};
   assign be = {1'b0, b};
   assign bz = (b == '0);
   // Unlisted or unknown selects fall to the default and yield 0, never X.
   always_comb begin
      result = '0;
      dz     = 1'b0;
      case (sel)
         OP_PASS: result = ae;
         OP_ADD:  result = ae + be;
         OP_SUB:  result = ae - be;
         OP_DIV:  begin dz = bz; result = bz ? {1'b0, {W{1'b1}}} : ae / be; end
         OP_MOD:  begin dz = bz; result = bz ? ae : ae % be; end
         OP_SHL:  result = {a, 1'b0};
         OP_SHR:  result = {2'b00, a[W-1:1]};
         OP_GT:   result = {{W{1'b0}}, a > b};
         default: result = '0;
      endcase
   end
endmodule

// File: rtl/alu.sv
// alu: registered ALU with one-cycle latency.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   in_valid    : samples a, b, sel when high
//   a, b, sel   : operands and function select
//   out         : registered result, held when in_valid is low
//   out_valid   : one-cycle pulse per new result
//   div_by_zero : registered flag accompanying out_valid
module alu
   import alu_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   sel,
   output logic [W:0]   out,
   output logic         out_valid,
   output logic         div_by_zero
);
   logic [W:0] res, out_d, out_q;
   logic       dz, out_valid_d, out_valid_q, dz_d, dz_q;
   alu_core #(.W(W)) u_core (.a(a), .b(b), .sel(sel), .result(res), .dz(dz));
   always_comb begin
      out_d       = in_valid ? res : out_q;
      out_valid_d = in_valid;
      dz_d        = in_valid & dz;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         dz_q        <= dz_d;
      end
   end
   assign out         = out_q;
   assign out_valid   = out_valid_q;
   assign div_by_zero = dz_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu.
module tb_alu;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] a = '0, b = '0;
   logic [2:0] sel = '0;
   logic [4:0] out;
   logic       out_valid, div_by_zero;
   int checks = 0;
   int errors = 0;
   logic [4:0] exp_sw [8] = '{5'd3, 5'd5, 5'd1, 5'd1, 5'd1, 5'd6, 5'd1, 5'd1};

   alu #(.W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .sel(sel),
      .out(out), .out_valid(out_valid), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic op(input logic v, input logic [3:0] ai, input logic [3:0] bi, input logic [2:0] si);
      in_valid = v;
      a = ai;
      b = bi;
      sel = si;
      @(posedge clk);
      #1;
   endtask

   task automatic res(input string tag, input logic [4:0] eo, input logic ev, input logic ed);
      check({tag, "_out"}, {27'd0, out}, {27'd0, eo});
      check({tag, "_ov"}, {31'd0, out_valid}, {31'd0, ev});
      check({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, ed});
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      res("rst_hold", 5'd0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         op(1'b1, 4'd3, 4'd2, 3'(i));
         res($sformatf("sweep%0d", i), exp_sw[i], 1'b1, 1'b0);
      end
      op(1'b1, 4'd15, 4'd15, 3'b001); res("add_carry", 5'b11110, 1'b1, 1'b0);
      op(1'b1, 4'd2, 4'd3, 3'b010);   res("sub_wrap", 5'b11111, 1'b1, 1'b0);
      op(1'b1, 4'd15, 4'd0, 3'b101);  res("shl_msb", 5'b11110, 1'b1, 1'b0);
      op(1'b1, 4'd7, 4'd7, 3'b111);   res("gt_eq", 5'b00000, 1'b1, 1'b0);
      op(1'b1, 4'd9, 4'd0, 3'b011);   res("div0", 5'b01111, 1'b1, 1'b1);
      op(1'b1, 4'd9, 4'd0, 3'b100);   res("mod0", 5'b01001, 1'b1, 1'b1);
      op(1'b1, 4'd9, 4'd3, 3'b011);   res("div_ok", 5'b00011, 1'b1, 1'b0);
      op(1'b1, 4'd3, 4'd2, 3'b0x1);
      check("selx_nox", {31'd0, $isunknown(out)}, 32'd0);
      check("selx_ov", {31'd0, out_valid}, 32'd1);
      op(1'b1, 4'd5, 4'd1, 3'b001);   res("pre_hold", 5'b00110, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         op(1'b0, 4'd9, 4'd0, 3'b011);
         res($sformatf("hold%0d", i), 5'b00110, 1'b0, 1'b0);
      end
      op(1'b1, 4'd9, 4'd0, 3'b011);   res("pre_rst", 5'b01111, 1'b1, 1'b1);
      #2 rst = 1'b1;
      #1 res("async_rst", 5'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1 res("rst_edge", 5'd0, 1'b0, 1'b0);
      rst = 1'b0;
      op(1'b1, 4'd4, 4'd4, 3'b001);   res("post_rst", 5'b01000, 1'b1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
